rvfi_trace_ctrl: RTL and testbench
==================================

// Module: rvfi_trace_ctrl
// PURPOSE
// - Capture controller between core WB-stage RVFI retire signals and an off-core trace sink (UART bridge / sim monitor).
// - Sequences capture: optional arm-on-PC trigger, record limit, stop.
// - Packs each retired instruction into a 4-word record, buffers it in a FIFO, streams it out as 32-bit words over valid/ready.
// PARAMETERS
// - DEPTH    16  FIFO depth in records; power of 2, >=2
// - MAGIC  8'hA5  tag in bits [31:24] of record word 0
// PORTS
// - clk_i           in   1   clock; all logic on rising edge
// - rst_ni          in   1   async active-low reset
// - rvfi_valid      in   1   one instruction retires this cycle
// - rvfi_pc_rdata   in   32  PC of retiring instruction
// - rvfi_insn       in   32  retiring instruction word
// - rvfi_rd_addr    in   5   destination register (0 = none)
// - rvfi_rd_wdata   in   32  value written to rd
// - cfg_enable      in   1   level; 0 forces IDLE
// - cfg_trig_en     in   1   1: wait for cfg_trig_pc before capturing
// - cfg_trig_pc     in   32  trigger PC
// - cfg_limit       in   16  records to capture; 0 = unlimited
// - cfg_clear       in   1   pulse: flush FIFO, clear status, return to IDLE
// - out_valid       out  1   out_data holds a valid word
// - out_ready       in   1   sink accepts word when out_valid&out_ready
// - out_data        out  32  trace word
// - out_last        out  1   word is word 3 of its record
// - sts_state       out  2   0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// - sts_overflow    out  1   sticky: >=1 record dropped
// - sts_drop_cnt    out  16  dropped records, saturating at 16'hFFFF
// - sts_level       out  $clog2(DEPTH)+1  records held in FIFO
// BEHAVIOUR
// - Reset: state IDLE; FIFO empty; out_valid=0, out_data=0, out_last=0; sts_* all 0; seq counter 0; word index 0.
// - IDLE: cfg_enable=1 -> ARMED if cfg_trig_en, else CAPTURE. cfg_enable=0 in any state -> IDLE next cycle. FIFO keeps draining.
// - ARMED: rvfi_valid & pc==cfg_trig_pc -> CAPTURE. The trigger instruction is itself captured that cycle.
// - CAPTURE: each rvfi_valid offers one record. Captured count (accepted + dropped) reaches cfg_limit (!=0) -> DONE. The limit-th record is still offered.
// - DONE: no capture. Leaves only via cfg_enable=0 or cfg_clear.
// - Record layout:
//   - w0 = {MAGIC, 3'b0, rd_addr, seq[15:0]}
//   - w1 = pc
//   - w2 = insn
//   - w3 = rd_wdata
// - seq increments on every offered record, accepted or dropped, wrapping 16'hFFFF->0. Gaps in seq reveal drops.
// - Push: offered record written iff FIFO not full. Full is sampled before any same-cycle pop, so pop never frees a slot in the same cycle.
// - Drop: full -> record discarded, sts_overflow=1, sts_drop_cnt+1 (saturating).
// - Latency: record pushed on edge N is presented as w0 with out_valid=1 after edge N+1 (FIFO was empty, no bypass).
// - Output: words w0..w3 in order. out_data/out_valid stable while out_valid&!out_ready. Word index advances only on handshake. Record popped on w3 handshake. Back-to-back records stream with no bubble.
// - cfg_clear has priority over everything:
//   - flush FIFO; out_valid=0 next cycle, even mid-record
//   - word index=0, seq=0, drop_cnt=0, overflow=0, state IDLE
//   - a same-cycle rvfi_valid is not captured
// - Count limits: captured-count register is 16 bits and saturates. Reset on entry to CAPTURE from IDLE/ARMED.
// - Pointers: log2(DEPTH)+1 bits; wrap naturally; full = MSBs differ & rest equal.
// TESTING
// - T1: trig_en=0, enable=1, 3 retires (pc 0x0,0x4,0x8), out_ready=1 -> 12 words; w0 seq 0,1,2; out_last on words 3,7,11.
// - T2: trig_en=1, trig_pc=0x100; retire pcs 0xF8,0xFC,0x100,0x104 -> ARMED until 0x100; exactly 2 records, first pc=0x100.
// - T3: limit=2; 5 retires -> 2 records out; sts_state=3 after 2nd retire; no further pushes.
// - T4: out_ready=0, DEPTH=16, 20 retires -> level=16, overflow=1, drop_cnt=4; release ready -> seq 0..15 out.
// - T5: stall out_ready=0 mid-record at w2 for 5 cycles -> out_data held = insn; resumes with w3.
// - T6: cfg_clear while streaming w1 with rvfi_valid=1 -> next cycle out_valid=0, level=0, state IDLE, status 0; async reset mid-record -> all reset values.

Source files
------------

// File: rtl/rvfi_trace_ctrl_if.sv
// Trace word stream from the capture controller to the trace sink.
// The master drives words and the slave accepts them with out_ready.
interface rvfi_trace_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/rvfi_trace_ctrl.sv
// RVFI retire capture: trigger/limit sequencing, record FIFO and
// a 4-word-per-record trace stream toward an off-core sink.
module rvfi_trace_ctrl #(
    parameter int unsigned DEPTH = 16,
    parameter logic [7:0]  MAGIC = 8'hA5
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     rvfi_valid,
    input  logic [31:0]              rvfi_pc_rdata,
    input  logic [31:0]              rvfi_insn,
    input  logic [4:0]               rvfi_rd_addr,
    input  logic [31:0]              rvfi_rd_wdata,
    input  logic                     cfg_enable,
    input  logic                     cfg_trig_en,
    input  logic [31:0]              cfg_trig_pc,
    input  logic [15:0]              cfg_limit,
    input  logic                     cfg_clear,
    rvfi_trace_ctrl_if.master        trace,
    output logic [1:0]               sts_state,
    output logic                     sts_overflow,
    output logic [15:0]              sts_drop_cnt,
    output logic [$clog2(DEPTH):0]   sts_level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic [15:0] seq;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] wdata;
    } rec_t;

    state_e      state_q;
    rec_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q, rd_nxt, level;
    logic [15:0] seq_q, cnt_q, drop_q, cnt_inc;
    logic        ovf_q, valid_q, last_q;
    logic [31:0] data_q;
    logic [1:0]  widx_q;
    logic        full, trig_hit, offer, push;
    rec_t        rec_in, head, nxt;

    function automatic logic [31:0] word_sel(rec_t r, logic [1:0] i);
        logic [31:0] w;
        unique case (i)
            2'd0: w = {MAGIC, 3'b000, r.rd, r.seq};
            2'd1: w = r.pc;
            2'd2: w = r.insn;
            default: w = r.wdata;
        endcase
        return w;
    endfunction

    assign level  = wr_ptr_q - rd_ptr_q;
    assign rd_nxt = rd_ptr_q + PTR_ONE;
    assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head   = mem_q[rd_ptr_q[AW-1:0]];
    assign nxt    = mem_q[rd_nxt[AW-1:0]];

    assign trig_hit = (state_q == ARMED) && (rvfi_pc_rdata == cfg_trig_pc);
    assign offer    = rvfi_valid && cfg_enable && !cfg_clear &&
                      ((state_q == CAPTURE) || trig_hit);
    assign push     = offer && !full;
    assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    assign rec_in   = '{rd: rvfi_rd_addr, seq: seq_q, pc: rvfi_pc_rdata,
                        insn: rvfi_insn, wdata: rvfi_rd_wdata};

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    end

    // Sequencing, record numbering and drop accounting
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (cfg_clear) begin
            state_q <= IDLE;
            seq_q   <= '0;
            cnt_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (offer) seq_q <= seq_q + 16'd1;
            if (offer && full) begin
                ovf_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
            if (!cfg_enable) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cnt_q   <= '0;
                        state_q <= cfg_trig_en ? ARMED : CAPTURE;
                    end
                    ARMED: if (offer) begin
                        cnt_q   <= 16'd1;
                        state_q <= (cfg_limit == 16'd1) ? DONE : CAPTURE;
                    end
                    CAPTURE: if (offer) begin
                        cnt_q <= cnt_inc;
                        if (cfg_limit != '0 && cnt_inc >= cfg_limit)
                            state_q <= DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    // FIFO pointers and the registered output word
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            widx_q   <= '0;
        end else if (cfg_clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            widx_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (!valid_q) begin
                if (level != '0) begin
                    valid_q <= 1'b1;
                    widx_q  <= '0;
                    data_q  <= word_sel(head, 2'd0);
                    last_q  <= 1'b0;
                end
            end else if (trace.out_ready) begin
                if (widx_q == 2'd3) begin
                    rd_ptr_q <= rd_nxt;
                    widx_q   <= '0;
                    last_q   <= 1'b0;
                    // Only records already held before this edge may follow
                    if (level > PTR_ONE) begin
                        data_q <= word_sel(nxt, 2'd0);
                    end else begin
                        valid_q <= 1'b0;
                        data_q  <= '0;
                    end
                end else begin
                    widx_q <= widx_q + 2'd1;
                    data_q <= word_sel(head, widx_q + 2'd1);
                    last_q <= (widx_q == 2'd2);
                end
            end
        end
    end

    assign trace.out_valid = valid_q;
    assign trace.out_data  = data_q;
    assign trace.out_last  = last_q;
    assign sts_state       = state_q;
    assign sts_overflow    = ovf_q;
    assign sts_drop_cnt    = drop_q;
    assign sts_level       = level;
endmodule

// File: tb/tb_rvfi_trace_ctrl.sv
// Directed bench for rvfi_trace_ctrl: vector table for basic streaming
// plus hand-written trigger, limit, overflow, stall, clear and reset cases.
module tb_rvfi_trace_ctrl;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        rvfi_valid;
    logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata;
    logic [4:0]  rvfi_rd_addr;
    logic        cfg_enable, cfg_trig_en, cfg_clear;
    logic [31:0] cfg_trig_pc;
    logic [15:0] cfg_limit;
    logic [1:0]  sts_state;
    logic        sts_overflow;
    logic [15:0] sts_drop_cnt;
    logic [4:0]  sts_level;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] q[$];

    rvfi_trace_ctrl_if trace();

    rvfi_trace_ctrl #(.DEPTH(16), .MAGIC(8'hA5)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rvfi_valid(rvfi_valid), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_insn(rvfi_insn), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata),
        .cfg_enable(cfg_enable), .cfg_trig_en(cfg_trig_en),
        .cfg_trig_pc(cfg_trig_pc), .cfg_limit(cfg_limit),
        .cfg_clear(cfg_clear), .trace(trace),
        .sts_state(sts_state), .sts_overflow(sts_overflow),
        .sts_drop_cnt(sts_drop_cnt), .sts_level(sts_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        int          k;
        logic        ev;
        logic [31:0] ed;
        logic        el;
        logic [4:0]  elv;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn,
                           input logic [4:0] rd, input logic [31:0] wd);
        rvfi_valid    = 1'b1;
        rvfi_pc_rdata = pc;
        rvfi_insn     = insn;
        rvfi_rd_addr  = rd;
        rvfi_rd_wdata = wd;
    endtask

    task automatic retire(input logic [31:0] pc);
        set_rec(pc, 32'h0000_0013 ^ pc, 5'd7, 32'h5500_0000 | pc);
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic drain(input int cycles);
        trace.out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (trace.out_valid) q.push_back(trace.out_data);
            tick();
        end
    endtask

    task automatic reinit();
        rvfi_valid = 1'b0;
        cfg_enable = 1'b0;
        cfg_clear  = 1'b1;
        tick();
        cfg_clear = 1'b0;
        q.delete();
    endtask

    initial begin
        rst_ni = 1'b0;
        rvfi_valid = 1'b0;
        rvfi_pc_rdata = '0;
        rvfi_insn = '0;
        rvfi_rd_addr = '0;
        rvfi_rd_wdata = '0;
        cfg_enable = 1'b0;
        cfg_trig_en = 1'b0;
        cfg_trig_pc = '0;
        cfg_limit = '0;
        cfg_clear = 1'b0;
        trace.out_ready = 1'b1;

        // w0 = {A5, 000, rd=k+1, seq=k}
        tbl[0]  = '{1'b1, 0, 1'b0, 32'h0,         1'b0, 5'd1};
        tbl[1]  = '{1'b1, 1, 1'b1, 32'hA501_0000, 1'b0, 5'd2};
        tbl[2]  = '{1'b1, 2, 1'b1, 32'h0000_0000, 1'b0, 5'd3};
        tbl[3]  = '{1'b0, 0, 1'b1, 32'h0010_0093, 1'b0, 5'd3};
        tbl[4]  = '{1'b0, 0, 1'b1, 32'hD000_0000, 1'b1, 5'd3};
        tbl[5]  = '{1'b0, 0, 1'b1, 32'hA502_0001, 1'b0, 5'd2};
        tbl[6]  = '{1'b0, 0, 1'b1, 32'h0000_0004, 1'b0, 5'd2};
        tbl[7]  = '{1'b0, 0, 1'b1, 32'h0010_0094, 1'b0, 5'd2};
        tbl[8]  = '{1'b0, 0, 1'b1, 32'hD000_0001, 1'b1, 5'd2};
        tbl[9]  = '{1'b0, 0, 1'b1, 32'hA503_0002, 1'b0, 5'd1};
        tbl[10] = '{1'b0, 0, 1'b1, 32'h0000_0008, 1'b0, 5'd1};
        tbl[11] = '{1'b0, 0, 1'b1, 32'h0010_0095, 1'b0, 5'd1};
        tbl[12] = '{1'b0, 0, 1'b1, 32'hD000_0002, 1'b1, 5'd1};
        tbl[13] = '{1'b0, 0, 1'b0, 32'h0,         1'b0, 5'd0};

        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check("rst_valid", {31'b0, trace.out_valid}, 0);
        check("rst_data", trace.out_data, 0);
        check("rst_last", {31'b0, trace.out_last}, 0);
        check("rst_state", {30'b0, sts_state}, 0);
        check("rst_level", {27'b0, sts_level}, 0);
        check("rst_ovf", {31'b0, sts_overflow}, 0);
        check("rst_drop", {16'b0, sts_drop_cnt}, 0);

        // T1: free-running capture, vector table
        cfg_enable = 1'b1;
        tick();
        check("t1_state", {30'b0, sts_state}, 2);
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rv)
                set_rec(32'(4 * tbl[i].k), 32'h0010_0093 + 32'(tbl[i].k),
                        5'(tbl[i].k + 1), 32'hD000_0000 + 32'(tbl[i].k));
            else
                rvfi_valid = 1'b0;
            tick();
            check($sformatf("t1_valid[%0d]", i),
                  {31'b0, trace.out_valid}, {31'b0, tbl[i].ev});
            check($sformatf("t1_level[%0d]", i),
                  {27'b0, sts_level}, {27'b0, tbl[i].elv});
            if (tbl[i].ev) begin
                check($sformatf("t1_data[%0d]", i), trace.out_data, tbl[i].ed);
                check($sformatf("t1_last[%0d]", i),
                      {31'b0, trace.out_last}, {31'b0, tbl[i].el});
            end
        end

        // T2: arm on trigger PC
        reinit();
        trace.out_ready = 1'b0;
        cfg_enable  = 1'b1;
        cfg_trig_en = 1'b1;
        cfg_trig_pc = 32'h100;
        tick();
        check("t2_armed", {30'b0, sts_state}, 1);
        retire(32'hF8);
        retire(32'hFC);
        check("t2_still_armed", {30'b0, sts_state}, 1);
        check("t2_no_push", {27'b0, sts_level}, 0);
        retire(32'h100);
        check("t2_capture", {30'b0, sts_state}, 2);
        retire(32'h104);
        check("t2_level", {27'b0, sts_level}, 2);
        drain(20);
        check("t2_words", q.size(), 8);
        if (q.size() == 8) begin
            check("t2_pc0", q[1], 32'h100);
            check("t2_pc1", q[5], 32'h104);
            check("t2_seq0", q[0], 32'hA507_0000);
            check("t2_seq1", q[4], 32'hA507_0001);
        end
        cfg_trig_en = 1'b0;

        // T3: record limit
        reinit();
        trace.out_ready = 1'b0;
        cfg_limit  = 16'd2;
        cfg_enable = 1'b1;
        tick();
        retire(32'h10);
        check("t3_cap", {30'b0, sts_state}, 2);
        retire(32'h14);
        check("t3_done", {30'b0, sts_state}, 3);
        retire(32'h18);
        retire(32'h1C);
        retire(32'h20);
        check("t3_level", {27'b0, sts_level}, 2);
        check("t3_stay_done", {30'b0, sts_state}, 3);
        drain(20);
        check("t3_words", q.size(), 8);
        if (q.size() == 8) check("t3_pc1", q[5], 32'h14);
        cfg_limit = 16'd0;

        // T4: overflow with a stalled sink, then gapless drain
        reinit();
        trace.out_ready = 1'b0;
        cfg_enable = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) retire(32'(i * 4));
        check("t4_level", {27'b0, sts_level}, 16);
        check("t4_ovf", {31'b0, sts_overflow}, 1);
        check("t4_drop", {16'b0, sts_drop_cnt}, 4);
        drain(64);
        check("t4_words", q.size(), 64);
        check("t4_empty", {31'b0, trace.out_valid}, 0);
        if (q.size() == 64)
            for (int i = 0; i < 16; i++)
                check($sformatf("t4_seq[%0d]", i), {16'b0, q[4 * i][15:0]}, i);

        // T5: stall mid-record on w2
        reinit();
        check("t5_ovf_clr", {31'b0, sts_overflow}, 0);
        check("t5_drop_clr", {16'b0, sts_drop_cnt}, 0);
        trace.out_ready = 1'b1;
        cfg_enable = 1'b1;
        tick();
        set_rec(32'h200, 32'hCAFE_0013, 5'd9, 32'h1234_5678);
        tick();
        rvfi_valid = 1'b0;
        repeat (3) tick();
        check("t5_w2", trace.out_data, 32'hCAFE_0013);
        trace.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_hold_valid", {31'b0, trace.out_valid}, 1);
            check("t5_hold_data", trace.out_data, 32'hCAFE_0013);
        end
        trace.out_ready = 1'b1;
        tick();
        check("t5_w3", trace.out_data, 32'h1234_5678);
        check("t5_w3_last", {31'b0, trace.out_last}, 1);
        tick();

        // T6: clear mid-record, then async reset mid-record
        reinit();
        trace.out_ready = 1'b1;
        cfg_enable = 1'b1;
        tick();
        retire(32'h300);
        retire(32'h304);
        tick();
        check("t6_w1", trace.out_data, 32'h300);
        set_rec(32'h308, 32'h0, 5'd3, 32'h0);
        cfg_clear = 1'b1;
        tick();
        cfg_clear = 1'b0;
        rvfi_valid = 1'b0;
        check("t6_clr_valid", {31'b0, trace.out_valid}, 0);
        check("t6_clr_level", {27'b0, sts_level}, 0);
        check("t6_clr_state", {30'b0, sts_state}, 0);
        tick();
        check("t6_no_capture", {27'b0, sts_level}, 0);
        set_rec(32'h30C, 32'h0, 5'd3, 32'h0);
        tick();
        rvfi_valid = 1'b0;
        tick();
        check("t6_seq_restart", trace.out_data, 32'hA503_0000);
        tick();
        #3;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_valid", {31'b0, trace.out_valid}, 0);
        check("t6_rst_data", trace.out_data, 0);
        check("t6_rst_state", {30'b0, sts_state}, 0);
        check("t6_rst_level", {27'b0, sts_level}, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("t6_post_rst", {31'b0, trace.out_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
